// File: rtl/ttt_turn_sequencer.sv
// Turn sequencer/arbiter sharing one tic-tac-toe board datapath between two players.
// Validates moves, forwards them to the board, acks/naks, times turns out and keeps match scores.
//
// state | meaning
// IDLE  | after reset, waiting for the first start
// CLEAR | one-cycle board clear, pick the opening player
// WAIT  | waiting for the on-turn player's request, turn timer running
// ISSUE | move strobed to the board
// CHECK | board verdict sampled, ack/nak issued
// DONE  | game over, results held until the next start
module ttt_turn_sequencer #(
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int SCORE_W        = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               p0_req,
    input  logic [1:0]         p0_row,
    input  logic [1:0]         p0_col,
    output logic               p0_ack,
    output logic               p0_nak,
    input  logic               p1_req,
    input  logic [1:0]         p1_row,
    input  logic [1:0]         p1_col,
    output logic               p1_ack,
    output logic               p1_nak,
    output logic               brd_clear,
    output logic               brd_update,
    output logic               brd_player,
    output logic [1:0]         brd_row,
    output logic [1:0]         brd_col,
    input  logic               brd_gameover,
    input  logic               brd_winner,
    input  logic               brd_draw,
    input  logic               brd_err,
    output logic               turn,
    output logic               in_game,
    output logic               game_done,
    output logic               timeout_loss,
    output logic [3:0]         move_cnt,
    output logic [SCORE_W-1:0] score0,
    output logic [SCORE_W-1:0] score1,
    output logic [SCORE_W-1:0] draws
);

    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_WAIT  = 3'd2,
        S_ISSUE = 3'd3,
        S_CHECK = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic               turn_q, turn_d;
    logic               first_q, first_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic [1:0]         row_q, row_d;
    logic [1:0]         col_q, col_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [SCORE_W-1:0] s0_q, s0_d;
    logic [SCORE_W-1:0] s1_q, s1_d;
    logic [SCORE_W-1:0] dr_q, dr_d;
    logic               tl_q, tl_d;

    logic               req_on;
    logic [1:0]         row_on;
    logic [1:0]         col_on;
    logic               ack_on;
    logic               nak_on;

    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            turn_q  <= 1'b0;
            first_q <= 1'b0;
            timer_q <= '0;
            row_q   <= 2'd0;
            col_q   <= 2'd0;
            cnt_q   <= 4'd0;
            s0_q    <= '0;
            s1_q    <= '0;
            dr_q    <= '0;
            tl_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            turn_q  <= turn_d;
            first_q <= first_d;
            timer_q <= timer_d;
            row_q   <= row_d;
            col_q   <= col_d;
            cnt_q   <= cnt_d;
            s0_q    <= s0_d;
            s1_q    <= s1_d;
            dr_q    <= dr_d;
            tl_q    <= tl_d;
        end
    end

    // Only the on-turn requester is ever looked at; the other one just stays pending.
    assign req_on = turn_q ? p1_req : p0_req;
    assign row_on = turn_q ? p1_row : p0_row;
    assign col_on = turn_q ? p1_col : p0_col;

    always_comb begin
        state_d = state_q;
        turn_d  = turn_q;
        first_d = first_q;
        timer_d = timer_q;
        row_d   = row_q;
        col_d   = col_q;
        cnt_d   = cnt_q;
        s0_d    = s0_q;
        s1_d    = s1_q;
        dr_d    = dr_q;
        tl_d    = tl_q;
        ack_on  = 1'b0;
        nak_on  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_CLEAR;
            end
            S_CLEAR: begin
                cnt_d   = 4'd0;
                timer_d = '0;
                tl_d    = 1'b0;
                turn_d  = first_q;
                first_d = ~first_q;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (start) begin
                    state_d = S_CLEAR;
                end else begin
                    // Timer saturates at its terminal value so it can never wrap.
                    if (timer_q != TO_LAST) timer_d = timer_q + 1'b1;
                    if (req_on && (row_on == 2'd3 || col_on == 2'd3)) nak_on = 1'b1;
                    if (req_on && row_on != 2'd3 && col_on != 2'd3) begin
                        row_d   = row_on;
                        col_d   = col_on;
                        state_d = S_ISSUE;
                    end else if (timer_q == TO_LAST) begin
                        if (turn_q) s0_d = sat_inc(s0_q);
                        else        s1_d = sat_inc(s1_q);
                        tl_d    = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_ISSUE: begin
                state_d = start ? S_CLEAR : S_CHECK;
            end
            S_CHECK: begin
                if (start) begin
                    state_d = S_CLEAR;
                end else if (brd_err) begin
                    nak_on  = 1'b1;
                    state_d = S_WAIT;
                end else begin
                    ack_on = 1'b1;
                    cnt_d  = cnt_q + 4'd1;
                    if (brd_gameover) begin
                        if (brd_draw)        dr_d = sat_inc(dr_q);
                        else if (brd_winner) s1_d = sat_inc(s1_q);
                        else                 s0_d = sat_inc(s0_q);
                        state_d = S_DONE;
                    end else begin
                        turn_d  = ~turn_q;
                        timer_d = '0;
                        state_d = S_WAIT;
                    end
                end
            end
            S_DONE: begin
                if (start) state_d = S_CLEAR;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign p0_ack = ack_on & ~turn_q;
    assign p1_ack = ack_on &  turn_q;
    assign p0_nak = nak_on & ~turn_q;
    assign p1_nak = nak_on &  turn_q;

    assign brd_clear  = (state_q == S_CLEAR);
    assign brd_update = (state_q == S_ISSUE);
    assign brd_player = (state_q == S_ISSUE) ? turn_q : 1'b0;
    assign brd_row    = (state_q == S_ISSUE) ? row_q : 2'd0;
    assign brd_col    = (state_q == S_ISSUE) ? col_q : 2'd0;

    assign turn         = turn_q;
    assign in_game      = (state_q == S_CLEAR) || (state_q == S_WAIT) ||
                          (state_q == S_ISSUE) || (state_q == S_CHECK);
    assign game_done    = (state_q == S_DONE);
    assign timeout_loss = tl_q;
    assign move_cnt     = cnt_q;
    assign score0       = s0_q;
    assign score1       = s1_q;
    assign draws        = dr_q;

endmodule

// File: tb/tb_ttt_turn_sequencer.sv
// Directed bench for ttt_turn_sequencer: moves, naks, board errors, wins, draws, timeout, abort, reset.
module tb_ttt_turn_sequencer;

    logic       clk;
    logic       rst;
    logic       start;
    logic       p0_req, p1_req;
    logic [1:0] p0_row, p0_col, p1_row, p1_col;
    logic       p0_ack, p0_nak, p1_ack, p1_nak;
    logic       brd_clear, brd_update, brd_player;
    logic [1:0] brd_row, brd_col;
    logic       brd_gameover, brd_winner, brd_draw, brd_err;
    logic       turn, in_game, game_done, timeout_loss;
    logic [3:0] move_cnt;
    logic [3:0] score0, score1, draws;

    int n_chk;
    int n_bad;

    ttt_turn_sequencer #(.TIMEOUT_CYCLES(8), .SCORE_W(4)) dut (
        .clk(clk), .rst(rst), .start(start),
        .p0_req(p0_req), .p0_row(p0_row), .p0_col(p0_col), .p0_ack(p0_ack), .p0_nak(p0_nak),
        .p1_req(p1_req), .p1_row(p1_row), .p1_col(p1_col), .p1_ack(p1_ack), .p1_nak(p1_nak),
        .brd_clear(brd_clear), .brd_update(brd_update), .brd_player(brd_player),
        .brd_row(brd_row), .brd_col(brd_col),
        .brd_gameover(brd_gameover), .brd_winner(brd_winner), .brd_draw(brd_draw), .brd_err(brd_err),
        .turn(turn), .in_game(in_game), .game_done(game_done), .timeout_loss(timeout_loss),
        .move_cnt(move_cnt), .score0(score0), .score1(score1), .draws(draws)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entered in WAIT; plays one valid move through ISSUE and CHECK and returns in the next state.
    task automatic move(input logic p, input logic [1:0] r, input logic [1:0] c,
                        input logic go, input logic win, input logic drw, input logic err);
        if (p) begin p1_req = 1'b1; p1_row = r; p1_col = c; end
        else   begin p0_req = 1'b1; p0_row = r; p0_col = c; end
        brd_gameover = go; brd_winner = win; brd_draw = drw; brd_err = err;
        #1;
        chk("wait_no_nak", p ? p1_nak : p0_nak, 0);
        chk("wait_no_upd", brd_update, 0);
        tick();
        chk("iss_upd", brd_update, 1);
        chk("iss_player", brd_player, p);
        chk("iss_row", brd_row, r);
        chk("iss_col", brd_col, c);
        tick();
        chk("chk_ack", p ? p1_ack : p0_ack, !err);
        chk("chk_nak", p ? p1_nak : p0_nak, err);
        chk("chk_other_ack", p ? p0_ack : p1_ack, 0);
        if (p) p1_req = 1'b0; else p0_req = 1'b0;
        tick();
        brd_gameover = 0; brd_winner = 0; brd_draw = 0; brd_err = 0;
    endtask

    task automatic new_game();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("clr_pulse", brd_clear, 1);
        chk("clr_in_game", in_game, 1);
        tick();
    endtask

    initial begin
        n_chk = 0; n_bad = 0;
        rst = 1'b0; start = 0;
        p0_req = 0; p0_row = 0; p0_col = 0;
        p1_req = 0; p1_row = 0; p1_col = 0;
        brd_gameover = 0; brd_winner = 0; brd_draw = 0; brd_err = 0;
        #12;
        chk("rst_turn", turn, 0);
        chk("rst_in_game", in_game, 0);
        chk("rst_done", game_done, 0);
        chk("rst_clear", brd_clear, 0);
        chk("rst_cnt", move_cnt, 0);
        chk("rst_score0", score0, 0);
        rst = 1'b1;
        tick();

        // Game 1, p0 opens; p1 raises an off-turn request during CLEAR
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("g1_clear", brd_clear, 1);
        p1_req = 1'b1; p1_row = 2'd1; p1_col = 2'd1;
        tick();
        chk("g1_turn", turn, 0);
        p0_req = 1'b1; p0_row = 2'd3; p0_col = 2'd0;
        #1;
        chk("bad_row_nak", p0_nak, 1);
        chk("bad_row_noupd", brd_update, 0);
        chk("offturn_ack", p1_ack, 0);
        chk("offturn_nak", p1_nak, 0);
        tick();
        move(0, 2'd0, 2'd0, 0, 0, 0, 0);
        chk("m1_turn", turn, 1);
        chk("m1_cnt", move_cnt, 1);
        move(1, 2'd1, 2'd1, 0, 0, 0, 0);
        chk("m2_turn", turn, 0);
        move(0, 2'd1, 2'd1, 0, 0, 0, 1);
        chk("err_turn", turn, 0);
        chk("err_cnt", move_cnt, 2);
        move(0, 2'd0, 2'd1, 0, 0, 0, 0);
        move(1, 2'd2, 2'd2, 0, 0, 0, 0);
        move(0, 2'd0, 2'd2, 1, 0, 0, 0);
        chk("g1_done", game_done, 1);
        chk("g1_in_game", in_game, 0);
        chk("g1_score0", score0, 1);
        chk("g1_score1", score1, 0);
        chk("g1_cnt", move_cnt, 5);

        // Game 2, p1 opens; aborted after three moves
        new_game();
        chk("g2_turn", turn, 1);
        chk("g2_cnt", move_cnt, 0);
        move(1, 2'd0, 2'd0, 0, 0, 0, 0);
        move(0, 2'd1, 2'd0, 0, 0, 0, 0);
        move(1, 2'd2, 2'd0, 0, 0, 0, 0);
        chk("g2_cnt3", move_cnt, 3);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("abort_clear", brd_clear, 1);
        tick();
        chk("abort_cnt", move_cnt, 0);
        chk("abort_score0", score0, 1);
        chk("abort_score1", score1, 0);
        chk("g3_turn", turn, 0);

        // Game 3: p0 never moves, loses on timeout after 8 WAIT cycles
        for (int i = 0; i < 7; i++) tick();
        chk("to_not_yet", game_done, 0);
        tick();
        chk("to_done", game_done, 1);
        chk("to_loss", timeout_loss, 1);
        chk("to_score1", score1, 1);
        chk("to_score0", score0, 1);

        // Game 4: p1 opens, board reports a draw
        new_game();
        chk("g4_turn", turn, 1);
        chk("g4_tl_clr", timeout_loss, 0);
        move(1, 2'd1, 2'd1, 1, 0, 1, 0);
        chk("draw_cnt", draws, 1);
        chk("draw_score0", score0, 1);
        chk("draw_score1", score1, 1);
        chk("draw_done", game_done, 1);

        // Game 5: reset asserted while the move is in ISSUE
        new_game();
        chk("g5_turn", turn, 0);
        p0_req = 1'b1; p0_row = 2'd2; p0_col = 2'd1;
        tick();
        chk("g5_iss_upd", brd_update, 1);
        rst = 1'b0;
        #1;
        chk("rstm_upd", brd_update, 0);
        chk("rstm_row", brd_row, 0);
        chk("rstm_in_game", in_game, 0);
        chk("rstm_score0", score0, 0);
        chk("rstm_draws", draws, 0);
        p0_req = 1'b0;
        tick();
        rst = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
